// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared definitions for the QoS weighted-round-robin scheduler.
// Holds the FSM state encoding, the weight nibble width and a constant
// clog2 helper for the derived port widths.
package qos_wrr_scheduler_pkg;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  // Bits per VC weight field in weight_in.
  localparam int unsigned WeightW = 4;

  function automatic int unsigned qos_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qos_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, wdata     write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata           word at the head of the FIFO
//   full, empty     status flags derived from the occupancy count
//   level           current number of stored words
module qos_fifo
  import qos_wrr_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = qos_clog2(DEPTH),
  localparam int unsigned LVL_W = qos_clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_wr;
  logic              do_rd;

  // Fullness comes from the registered level, so a write into a full FIFO
  // is dropped even when a read happens in the same cycle.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign do_wr = push && !full;
  assign do_rd = pop && !empty;
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_wr && !do_rd) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!do_wr && do_rd) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// QoS weighted-round-robin scheduler.
// Words are steered into NUM_VC FIFOs by their top VC_W bits, drained into a
// single registered valid/ready output port by weighted round-robin, and
// counted per VC on each output handshake.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   init, umbral_high/low      configuration strobe and pause thresholds
//   weight_in                  per-VC weights, nibble k = VC k (0 acts as 1)
//   push, data_in              incoming word
//   pause                      registered backpressure with hysteresis
//   out_valid, out_data        scheduled word, held until out_ready
//   out_ready                  downstream accept
//   req, idx                   delivery counter read request and index
//   cnt_valid, cnt_data        counter read response (one cycle later)
//   active_out/idle_out/error_out  FSM state flags
module qos_wrr_scheduler
  import qos_wrr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 5,
  localparam int unsigned VC_W  = qos_clog2(NUM_VC),
  localparam int unsigned LVL_W = qos_clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [LVL_W-1:0]          umbral_high,
  input  logic [LVL_W-1:0]          umbral_low,
  input  logic [WeightW*NUM_VC-1:0] weight_in,
  input  logic                      push,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      pause,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  input  logic                      req,
  input  logic [VC_W:0]             idx,
  output logic                      cnt_valid,
  output logic [CNT_W-1:0]          cnt_data,
  output logic                      active_out,
  output logic                      idle_out,
  output logic                      error_out
);

  state_e               state_q, state_d;
  logic [LVL_W-1:0]     high_q, low_q;
  logic [WeightW-1:0]   weight_q [NUM_VC];
  logic [VC_W-1:0]      grant_q, grant_d, sel;
  logic [WeightW-1:0]   credit_q, credit_d, sel_credit, sel_weight;
  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;
  logic                 pause_q, pause_d;
  logic [CNT_W-1:0]     count_q [NUM_VC];
  logic                 cnt_valid_q;
  logic [CNT_W-1:0]     cnt_data_q;

  logic [NUM_VC-1:0]    fifo_push, fifo_pop, fifo_full, fifo_empty, nonempty;
  logic [DATA_W-1:0]    fifo_rdata [NUM_VC];
  logic [LVL_W-1:0]     fifo_level [NUM_VC];

  logic [VC_W-1:0]      push_vc, hs_vc;
  logic                 push_allowed, overflow, any_nonempty;
  logic                 load_en, pop_en, sel_drain, handshake;
  logic                 any_high, all_low;

  assign push_vc      = data_in[DATA_W-1 -: VC_W];
  assign push_allowed = (state_q == StIdle) || (state_q == StActive) || (state_q == StError);
  assign overflow     = push && push_allowed && fifo_full[push_vc];
  assign nonempty     = ~fifo_empty;
  assign any_nonempty = |nonempty;
  assign handshake    = out_valid_q && out_ready;
  assign hs_vc        = out_data_q[DATA_W-1 -: VC_W];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign fifo_push[v] = push && push_allowed && (push_vc == VC_W'(v));
    assign fifo_pop[v]  = pop_en && (sel == VC_W'(v));

    qos_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push[v]),
      .wdata (data_in),
      .pop   (fifo_pop[v]),
      .rdata (fifo_rdata[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v]),
      .level (fifo_level[v])
    );
  end

  // First non-empty VC in circular order starting at base+1; base itself is
  // the last candidate. Returns base when every FIFO is empty.
  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0]   base,
                                               input logic [NUM_VC-1:0] ne);
    logic [VC_W-1:0] cand;
    next_vc = base;
    for (int i = NUM_VC; i >= 1; i--) begin
      cand = base + VC_W'(i);
      if (ne[cand]) next_vc = cand;
    end
  endfunction

  // WRR: an empty granted VC forfeits its credit and the grant skips ahead
  // in the same cycle; otherwise rotate after weight words or on draining.
  always_comb begin
    sel        = grant_q;
    sel_credit = credit_q;
    if (fifo_empty[grant_q] && any_nonempty) begin
      sel        = next_vc(grant_q, nonempty);
      sel_credit = '0;
    end
    sel_weight = (weight_q[sel] == '0) ? WeightW'(1) : weight_q[sel];
    load_en    = !out_valid_q || out_ready;
    pop_en     = load_en && !fifo_empty[sel];
    sel_drain  = (fifo_level[sel] == LVL_W'(1)) && !fifo_push[sel];
    grant_d    = sel;
    credit_d   = sel_credit;
    if (pop_en) begin
      if ((({1'b0, sel_credit} + (WeightW + 1)'(1)) >= {1'b0, sel_weight}) || sel_drain) begin
        grant_d  = next_vc(sel, nonempty);
        credit_d = '0;
      end else begin
        credit_d = sel_credit + WeightW'(1);
      end
    end
  end

  // Hysteresis: set wins if thresholds are misconfigured so both hold.
  always_comb begin
    any_high = 1'b0;
    all_low  = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (fifo_level[v] >= high_q) any_high = 1'b1;
      if (fifo_level[v] > low_q)   all_low  = 1'b0;
    end
    pause_d = pause_q;
    if (any_high) begin
      pause_d = 1'b1;
    end else if (all_low) begin
      pause_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = StIdle;
      StIdle: begin
        // A push wins over init so INIT is never entered with data queued.
        if (push) begin
          state_d = StActive;
        end else if (init) begin
          state_d = StInit;
        end
      end
      StActive: if (!any_nonempty && !out_valid_q && !push) state_d = StIdle;
      StError:  state_d = StError;
      default:  state_d = StReset;
    endcase
    if (overflow) state_d = StError;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReset;
      high_q      <= LVL_W'(DEPTH);
      low_q       <= '0;
      grant_q     <= '0;
      credit_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pause_q     <= 1'b0;
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        weight_q[v] <= WeightW'(1);
        count_q[v]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      pause_q  <= pause_d;
      if (state_q == StInit && init) begin
        high_q <= umbral_high;
        low_q  <= umbral_low;
        for (int v = 0; v < NUM_VC; v++) begin
          weight_q[v] <= weight_in[v*WeightW +: WeightW];
        end
      end
      if (load_en) begin
        out_valid_q <= pop_en;
        if (pop_en) out_data_q <= fifo_rdata[sel];
      end
      if (handshake) count_q[hs_vc] <= count_q[hs_vc] + CNT_W'(1);
      cnt_valid_q <= req;
      if (req) begin
        // idx MSB set means idx >= NUM_VC.
        cnt_data_q <= idx[VC_W] ? '0 : count_q[idx[VC_W-1:0]];
      end
    end
  end

  assign pause      = pause_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign cnt_valid  = cnt_valid_q;
  assign cnt_data   = cnt_data_q;
  assign active_out = (state_q == StActive);
  assign idle_out   = (state_q == StIdle);
  assign error_out  = (state_q == StError);

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Directed self-checking bench for qos_wrr_scheduler (NUM_VC=4, DATA_W=12,
// DEPTH=8, CNT_W=5). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. they show the state after
// that edge.
module tb_qos_wrr_scheduler;

  logic        clk = 1'b0;
  logic        reset, init, push, out_ready, req;
  logic [3:0]  umbral_high, umbral_low;
  logic [15:0] weight_in;
  logic [11:0] data_in;
  logic [2:0]  idx;
  logic        pause, out_valid, cnt_valid, active_out, idle_out, error_out;
  logic [11:0] out_data;
  logic [4:0]  cnt_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qos_wrr_scheduler #(
    .NUM_VC (4),
    .DATA_W (12),
    .DEPTH  (8),
    .CNT_W  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_high (umbral_high),
    .umbral_low  (umbral_low),
    .weight_in   (weight_in),
    .push        (push),
    .data_in     (data_in),
    .pause       (pause),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .req         (req),
    .idx         (idx),
    .cnt_valid   (cnt_valid),
    .cnt_data    (cnt_data),
    .active_out  (active_out),
    .idle_out    (idle_out),
    .error_out   (error_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset, hold init for two latch cycles, then drop it into IDLE.
  task automatic do_init();
    reset       = 1'b0;
    init        = 1'b1;
    umbral_high = 4'd6;
    umbral_low  = 4'd2;
    weight_in   = 16'h1112;  // VC0=2, VC1..3=1
    tick();
    tick();
    tick();
    init = 1'b0;
    tick();
  endtask

  task automatic read_counter(input logic [2:0] i, output logic v, output logic [4:0] d);
    req = 1'b1;
    idx = i;
    tick();
    v   = cnt_valid;
    d   = cnt_data;
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; push = 1'b0; out_ready = 1'b0; req = 1'b0;
    idx = '0; data_in = '0; umbral_high = '0; umbral_low = '0; weight_in = '0;
    repeat (3) tick();
    n_checks++;
    if ({out_valid, pause, cnt_valid, active_out, idle_out, error_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {out_valid, pause, cnt_valid, active_out, idle_out, error_out});
    end
    n_checks++;
    if (out_data !== 12'h000 || cnt_data !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h cnt_data=%0d required 000/0", out_data, cnt_data);
    end
    do_init();
    n_checks++;
    if (idle_out !== 1'b1 || active_out !== 1'b0) begin
      n_fail++;
      $display("FAIL init_to_idle: idle=%b active=%b required 1/0", idle_out, active_out);
    end
  endtask

  task automatic test_single_push();
    out_ready = 1'b1;
    data_in   = 12'h005;
    push      = 1'b1;
    tick();
    push = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || active_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_edge_t: valid=%b active=%b required 0/1", out_valid, active_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 12'h005) begin
      n_fail++;
      $display("FAIL single_edge_t1: valid=%b data=%h required 1/005", out_valid, out_data);
    end
    tick();
    tick();
    n_checks++;
    if (idle_out !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: idle=%b valid=%b required 1/0", idle_out, out_valid);
    end
  endtask

  task automatic test_wrr();
    logic [11:0] exp_seq [8];
    logic        v;
    logic [4:0]  d;
    int          got;
    exp_seq = '{12'h010, 12'h011, 12'h410, 12'h012, 12'h013, 12'h411, 12'h412, 12'h413};
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push    = 1'b1;
      data_in = (i < 4) ? 12'h010 + 12'(i) : 12'h410 + 12'(i - 4);
      tick();
    end
    push      = 1'b0;
    out_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (out_valid) begin
        n_checks++;
        if (out_data !== exp_seq[got]) begin
          n_fail++;
          $display("FAIL wrr_order[%0d]: got %h required %h", got, out_data, exp_seq[got]);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL wrr_count: got %0d words required 8", got);
    end
    repeat (3) tick();
    read_counter(3'd0, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 5'd5) begin
      n_fail++;
      $display("FAIL count_vc0: valid=%b data=%0d required 1/5", v, d);
    end
    read_counter(3'd1, v, d);
    n_checks++;
    if (d !== 5'd4) begin
      n_fail++;
      $display("FAIL count_vc1: got %0d required 4", d);
    end
  endtask

  task automatic test_pause();
    // A VC0 word parks in the output register so all six VC2 words stay queued.
    out_ready = 1'b0;
    push      = 1'b1;
    data_in   = 12'h020;
    tick();
    for (int i = 0; i < 6; i++) begin
      data_in = 12'h800 + 12'(i);
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (pause !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_lag: got %b required 0", pause);
    end
    tick();
    n_checks++;
    if (pause !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_rise: got %b required 1", pause);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (pause !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_hold: got %b required 1", pause);
    end
    tick();
    n_checks++;
    if (pause !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_fall: got %b required 0", pause);
    end
    repeat (10) tick();
    n_checks++;
    if (idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_drain_idle: got %b required 1", idle_out);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] expw;
    logic        v;
    logic [4:0]  d;
    int          got;
    out_ready = 1'b0;
    push      = 1'b1;
    data_in   = 12'h030;
    tick();
    for (int i = 0; i < 9; i++) begin
      data_in = 12'hC00 + 12'(i);
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (error_out !== 1'b1 || active_out !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_error: error=%b active=%b required 1/0", error_out, active_out);
    end
    out_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        expw = (got == 0) ? 12'h030 : 12'hC00 + 12'(got - 1);
        n_checks++;
        if (out_data !== expw) begin
          n_fail++;
          $display("FAIL overflow_word[%0d]: got %h required %h", got, out_data, expw);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got != 9) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d words required 9", got);
    end
    n_checks++;
    if (error_out !== 1'b1 || idle_out !== 1'b0) begin
      n_fail++;
      $display("FAIL error_sticky: error=%b idle=%b required 1/0", error_out, idle_out);
    end
    read_counter(3'd3, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 5'd8) begin
      n_fail++;
      $display("FAIL count_vc3: valid=%b data=%0d required 1/8", v, d);
    end
    read_counter(3'd5, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 5'd0) begin
      n_fail++;
      $display("FAIL count_idx5: valid=%b data=%0d required 1/0", v, d);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic       v;
    logic [4:0] d;
    out_ready = 1'b0;
    push      = 1'b1;
    data_in   = 12'h111;
    tick();
    data_in = 12'h822;
    tick();
    push = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, pause, cnt_valid, active_out, idle_out, error_out} !== 6'b0
        || out_data !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_clear: flags=%b data=%h required 000000/000",
               {out_valid, pause, cnt_valid, active_out, idle_out, error_out}, out_data);
    end
    do_init();
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0 || idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_flushed: valid=%b idle=%b required 0/1", out_valid, idle_out);
    end
    read_counter(3'd3, v, d);
    n_checks++;
    if (d !== 5'd0) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d required 0", d);
    end
  endtask

  task automatic test_hold_and_wrap();
    logic       v;
    logic [4:0] d;
    int         hs;
    out_ready = 1'b0;
    push      = 1'b1;
    data_in   = 12'h455;
    tick();
    push = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 12'h455) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b data=%h required 1/455", k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    hs        = 0;
    for (int i = 0; i < 32; i++) begin
      if (out_valid) hs++;
      push    = 1'b1;
      data_in = 12'h400 + 12'(i);
      tick();
    end
    push = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) hs++;
      tick();
    end
    n_checks++;
    if (hs != 33) begin
      n_fail++;
      $display("FAIL wrap_handshakes: got %0d required 33", hs);
    end
    read_counter(3'd1, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 5'd1) begin
      n_fail++;
      $display("FAIL count_wrap: valid=%b data=%0d required 1/1", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_wrr();
    test_pause();
    test_overflow();
    test_reset_mid_transfer();
    test_hold_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
